// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 set-2 scan code constants and sequencer state encoding
package ps2_pkg;

  // Set-2 prefix, control and response bytes
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_ERRF   = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_GAP  = 2'd2,
    ST_SKIP = 2'd3
  } seq_state_t;

  // Sub-phases used while discarding the Pause tail (mirror IDLE/POP/GAP)
  localparam logic [1:0] SKP_WAIT = 2'd0;
  localparam logic [1:0] SKP_DROP = 2'd1;
  localparam logic [1:0] SKP_GAP  = 2'd2;

  // Keyboard responses that carry no key information
  function automatic logic is_response(input logic [7:0] c);
    return (c == SC_BAT) || (c == SC_ACK) || (c == SC_ECHO) || (c == SC_RESEND);
  endfunction

  // Bytes that signal a keyboard-side error or buffer overrun
  function automatic logic is_error(input logic [7:0] c);
    return (c == SC_ERR0) || (c == SC_ERRF);
  endfunction

endpackage

// File: rtl/ps2_held_table.sv
// rtl/ps2_held_table.sv - 512-entry held-key bitmap with registered any_held
module ps2_held_table (
  input  logic       clk,
  input  logic       rst,
  input  logic       set,
  input  logic       clr,
  input  logic       clr_all,
  input  logic [8:0] idx,
  output logic       hit,
  output logic       any_held
);

  logic [511:0] bits_q;
  logic [511:0] bits_d;

  assign hit = bits_q[idx];

  // Next table value; a bulk clear beats any single-key update in the same cycle
  always_comb begin
    bits_d = bits_q;
    if (clr_all) begin
      bits_d = '0;
    end else if (set) begin
      bits_d[idx] = 1'b1;
    end else if (clr) begin
      bits_d[idx] = 1'b0;
    end
  end

  // any_held is taken from the next value so it moves in step with the event pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      bits_q   <= '0;
      any_held <= 1'b0;
    end else begin
      bits_q   <= bits_d;
      any_held <= |bits_d;
    end
  end

endmodule

// File: rtl/ps2_scan_sequencer.sv
// rtl/ps2_scan_sequencer.sv - pops the PS/2 receive FIFO and emits clean key events
module ps2_scan_sequencer #(
  parameter bit FILTER_REPEAT = 1'b1,
  parameter int PAUSE_SKIP    = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_ready,
  input  logic [7:0] fifo_data,
  input  logic       fifo_ovf,
  output logic       nextdata_n,
  output logic       ev_valid,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic [7:0] press_count,
  output logic       any_held,
  output logic       err_sticky
);
  import ps2_pkg::*;

  seq_state_t  state;
  logic [1:0]  skip_ph;
  logic [7:0]  skip_cnt;
  logic [7:0]  byte_q;
  logic        ext_pend;
  logic        brk_pend;

  logic        is_key;
  logic        key_pop;
  logic        tbl_hit;
  logic        tbl_set;
  logic        tbl_clr;
  logic        key_emit;
  logic        new_press;

  // Classify the popped byte and derive held-table updates for the POP cycle
  always_comb begin
    is_key    = !((byte_q == SC_EXT) || (byte_q == SC_BRK) || (byte_q == SC_PAUSE) ||
                  is_error(byte_q) || is_response(byte_q));
    key_pop   = (state == ST_POP) && is_key;
    tbl_set   = key_pop && !brk_pend;
    tbl_clr   = key_pop && brk_pend;
    key_emit  = brk_pend || !(FILTER_REPEAT && tbl_hit);
    new_press = !brk_pend && !tbl_hit;
  end

  ps2_held_table u_held (
    .clk      (clk),
    .rst      (rst),
    .set      (tbl_set),
    .clr      (tbl_clr),
    .clr_all  (fifo_ovf),
    .idx      ({ext_pend, byte_q}),
    .hit      (tbl_hit),
    .any_held (any_held)
  );

  // Pop handshake, prefix decode, event generation and press counting
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      skip_ph     <= SKP_WAIT;
      skip_cnt    <= 8'd0;
      byte_q      <= 8'd0;
      ext_pend    <= 1'b0;
      brk_pend    <= 1'b0;
      nextdata_n  <= 1'b1;
      ev_valid    <= 1'b0;
      ev_code     <= 8'd0;
      ev_ext      <= 1'b0;
      ev_break    <= 1'b0;
      press_count <= 8'd0;
      err_sticky  <= 1'b0;
    end else begin
      ev_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fifo_ready) begin
            byte_q     <= fifo_data;
            nextdata_n <= 1'b0;
            state      <= ST_POP;
          end
        end
        ST_POP: begin
          nextdata_n <= 1'b1;
          state      <= ST_GAP;
          if (byte_q == SC_EXT) begin
            ext_pend <= 1'b1;
          end else if (byte_q == SC_BRK) begin
            brk_pend <= 1'b1;
          end else if (byte_q == SC_PAUSE) begin
            skip_cnt    <= 8'(PAUSE_SKIP);
            skip_ph     <= SKP_GAP;
            state       <= ST_SKIP;
            ev_valid    <= 1'b1;
            ev_code     <= SC_PAUSE;
            ev_ext      <= 1'b0;
            ev_break    <= 1'b0;
            press_count <= press_count + 8'd1;
            ext_pend    <= 1'b0;
            brk_pend    <= 1'b0;
          end else if (is_error(byte_q)) begin
            err_sticky <= 1'b1;
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
          end else if (is_response(byte_q)) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
          end else begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
            if (key_emit) begin
              ev_valid <= 1'b1;
              ev_code  <= byte_q;
              ev_ext   <= ext_pend;
              ev_break <= brk_pend;
              if (new_press) begin
                press_count <= press_count + 8'd1;
              end
            end
          end
        end
        ST_GAP: begin
          state <= ST_IDLE;
        end
        ST_SKIP: begin
          case (skip_ph)
            SKP_WAIT: begin
              if (fifo_ready) begin
                nextdata_n <= 1'b0;
                skip_ph    <= SKP_DROP;
              end
            end
            SKP_DROP: begin
              nextdata_n <= 1'b1;
              skip_cnt   <= skip_cnt - 8'd1;
              skip_ph    <= SKP_GAP;
            end
            SKP_GAP: begin
              if (skip_cnt == 8'd0) begin
                state <= ST_IDLE;
              end
              skip_ph <= SKP_WAIT;
            end
            default: begin
              skip_ph <= SKP_WAIT;
            end
          endcase
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
      if (fifo_ovf) begin
        err_sticky <= 1'b1;
        ext_pend   <= 1'b0;
        brk_pend   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// tb/tb_ps2_scan_sequencer.sv - directed bench with a ps2_keyboard FIFO model
module tb_ps2_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_ready;
  logic [7:0] fifo_data;
  logic       fifo_ovf;
  logic       hold;

  logic       nextdata_n, ev_valid, ev_ext, ev_break, any_held, err_sticky;
  logic [7:0] ev_code, press_count;
  logic       nf_nextdata_n, nf_ev_valid, nf_ev_ext, nf_ev_break, nf_any_held, nf_err_sticky;
  logic [7:0] nf_ev_code, nf_press_count;

  logic [7:0] fifo_q[$];
  int         fifo_cnt;
  logic [7:0] fifo_head;
  logic [9:0] ev_log[$];
  logic       held_log[$];
  logic [9:0] nf_log[$];
  int         hs_err;
  int         gap_cnt;
  logic       nd_prev;
  logic       rdy_prev;
  int         n_checks;
  int         n_pass;

  always #5 clk = ~clk;

  assign fifo_ready = (fifo_cnt != 0) && !hold;
  assign fifo_data  = fifo_head;

  ps2_scan_sequencer #(.FILTER_REPEAT(1'b1), .PAUSE_SKIP(7)) dut (
    .clk(clk), .rst(rst), .fifo_ready(fifo_ready), .fifo_data(fifo_data), .fifo_ovf(fifo_ovf),
    .nextdata_n(nextdata_n), .ev_valid(ev_valid), .ev_code(ev_code), .ev_ext(ev_ext),
    .ev_break(ev_break), .press_count(press_count), .any_held(any_held), .err_sticky(err_sticky)
  );

  ps2_scan_sequencer #(.FILTER_REPEAT(1'b0), .PAUSE_SKIP(7)) dut_nf (
    .clk(clk), .rst(rst), .fifo_ready(fifo_ready), .fifo_data(fifo_data), .fifo_ovf(fifo_ovf),
    .nextdata_n(nf_nextdata_n), .ev_valid(nf_ev_valid), .ev_code(nf_ev_code), .ev_ext(nf_ev_ext),
    .ev_break(nf_ev_break), .press_count(nf_press_count), .any_held(nf_any_held),
    .err_sticky(nf_err_sticky)
  );

  task automatic refresh();
    fifo_cnt  = fifo_q.size();
    fifo_head = (fifo_cnt != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [9:0] ev_at(input int i);
    return (i < ev_log.size()) ? ev_log[i] : 10'h3FF;
  endfunction

  function automatic logic held_at(input int i);
    return (i < held_log.size()) ? held_log[i] : 1'bx;
  endfunction

  // FIFO model: pop on a low nextdata_n; also police the pop handshake
  always @(negedge clk) begin
    if (nextdata_n === 1'b0) begin
      if (!rdy_prev) hs_err++;
      if (nd_prev) hs_err++;
      if (gap_cnt < 2) hs_err++;
      gap_cnt = 0;
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      else hs_err++;
      refresh();
    end else if (gap_cnt < 1000) begin
      gap_cnt++;
    end
    nd_prev  = (nextdata_n === 1'b0);
    rdy_prev = fifo_ready;
    if (ev_valid === 1'b1) begin
      ev_log.push_back({ev_code, ev_ext, ev_break});
      held_log.push_back(any_held);
    end
    if (nf_ev_valid === 1'b1) nf_log.push_back({nf_ev_code, nf_ev_ext, nf_ev_break});
  end

  task automatic push1(input logic [7:0] b);
    fifo_q.push_back(b);
    refresh();
  endtask

  task automatic clear_logs();
    ev_log.delete();
    held_log.delete();
    nf_log.delete();
  endtask

  task automatic drain(input string tag, input bit wiggle);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (wiggle) hold = ((i % 5) < 2);
      if (fifo_cnt == 0) break;
    end
    hold = 1'b0;
    check_eq(tag, fifo_cnt, 0);
    repeat (6) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_checks = 0; n_pass = 0; hs_err = 0; gap_cnt = 100;
    nd_prev = 1'b0; rdy_prev = 1'b0;
    rst = 1'b0; hold = 1'b0; fifo_ovf = 1'b0;
    refresh();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_nextdata_n", nextdata_n, 1);
    check_eq("rst_ev", {ev_valid, ev_code, ev_ext, ev_break}, 0);
    check_eq("rst_press_count", press_count, 0);
    check_eq("rst_any_held", any_held, 0);
    check_eq("rst_err", err_sticky, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: simple make/break
    clear_logs();
    push1(8'h1C); push1(8'hF0); push1(8'h1C);
    drain("t1_drain", 1'b0);
    check_eq("t1_nev", ev_log.size(), 2);
    check_eq("t1_ev0", ev_at(0), {8'h1C, 1'b0, 1'b0});
    check_eq("t1_ev1", ev_at(1), {8'h1C, 1'b0, 1'b1});
    check_eq("t1_held0", held_at(0), 1);
    check_eq("t1_held1", held_at(1), 0);
    check_eq("t1_count", press_count, 1);
    check_eq("t1_hs", hs_err, 0);

    // 2: extended make/break, prefixes produce no events
    clear_logs();
    push1(8'hE0); push1(8'h75); push1(8'hE0); push1(8'hF0); push1(8'h75);
    drain("t2_drain", 1'b0);
    check_eq("t2_nev", ev_log.size(), 2);
    check_eq("t2_ev0", ev_at(0), {8'h75, 1'b1, 1'b0});
    check_eq("t2_ev1", ev_at(1), {8'h75, 1'b1, 1'b1});
    check_eq("t2_count", press_count, 2);
    check_eq("t2_any_held", any_held, 0);

    // 3: typematic repeats, filtered vs forwarded
    clear_logs();
    push1(8'h1C); push1(8'h1C); push1(8'h1C); push1(8'hF0); push1(8'h1C);
    drain("t3_drain", 1'b0);
    check_eq("t3_nev", ev_log.size(), 2);
    check_eq("t3_ev0", ev_at(0), {8'h1C, 1'b0, 1'b0});
    check_eq("t3_ev1", ev_at(1), {8'h1C, 1'b0, 1'b1});
    check_eq("t3_count", press_count, 3);
    check_eq("t3_nf_nev", nf_log.size(), 4);
    check_eq("t3_nf_count", nf_press_count, 3);

    // 4: Pause sequence with ready toggling
    clear_logs();
    push1(8'hE1); push1(8'h14); push1(8'h77); push1(8'hE1); push1(8'hF0);
    push1(8'h14); push1(8'hF0); push1(8'h77); push1(8'h29);
    drain("t4_drain", 1'b1);
    check_eq("t4_nev", ev_log.size(), 2);
    check_eq("t4_ev0", ev_at(0), {8'hE1, 1'b0, 1'b0});
    check_eq("t4_ev1", ev_at(1), {8'h29, 1'b0, 1'b0});
    check_eq("t4_count", press_count, 5);
    check_eq("t4_hs", hs_err, 0);
    check_eq("t4_err", err_sticky, 0);

    // 5: overflow clears held keys and sets the sticky error
    clear_logs();
    push1(8'h1C);
    drain("t5_drain_a", 1'b0);
    check_eq("t5_count_a", press_count, 6);
    check_eq("t5_held_a", any_held, 1);
    fifo_ovf = 1'b1;
    @(posedge clk); #1;
    fifo_ovf = 1'b0;
    @(posedge clk); #1;
    check_eq("t5_err", err_sticky, 1);
    check_eq("t5_held_b", any_held, 0);
    clear_logs();
    push1(8'hF0); push1(8'h1C);
    drain("t5_drain_b", 1'b0);
    check_eq("t5_nev", ev_log.size(), 1);
    check_eq("t5_ev0", ev_at(0), {8'h1C, 1'b0, 1'b1});
    check_eq("t5_count_b", press_count, 6);

    // 6: reset in the middle of a pop
    clear_logs();
    push1(8'h1C);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        if (nextdata_n === 1'b0) begin
          seen = 1'b1;
          break;
        end
      end
      check_eq("t6_pop_seen", seen, 1);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("t6_nextdata_n", nextdata_n, 1);
    check_eq("t6_ev", {ev_valid, ev_code, ev_ext, ev_break}, 0);
    check_eq("t6_count", press_count, 0);
    check_eq("t6_held", any_held, 0);
    check_eq("t6_err", err_sticky, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    clear_logs();
    fifo_q.delete();
    refresh();
    push1(8'h1C);
    drain("t6_drain", 1'b0);
    check_eq("t6_nev", ev_log.size(), 1);
    check_eq("t6_ev0", ev_at(0), {8'h1C, 1'b0, 1'b0});
    check_eq("t6_count_b", press_count, 1);
    check_eq("t6_hs", hs_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
